// File: rtl/rom_link_tx.sv
// rom_link_tx: transmit side of the board-to-board ROM->RAM link.
// Walks every ROM address through READ_ROM, WRITE_RAM and READ_RAM phases.
// Each address is held for one slot of the slow link clock. The peer samples
// on the rising edge of link_clk, which falls in the middle of the slot.
module rom_link_tx #(
    parameter int DATA_W  = 4,
    parameter int ADDR_W  = 4,
    parameter int CLK_DIV = 50_000_000,
    parameter int ROM_MUL = 1,
    parameter int ROM_ADD = 0,
    parameter int PASSES  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              link_clk,
    output logic              wr_en,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data,
    output logic [DATA_W-1:0] leds,
    output logic [1:0]        phase,
    output logic              busy,
    output logic              done,
    output logic [7:0]        pass_cnt
);

    // A divide ratio of 1 still needs a 1-bit counter so the tick compare stays legal.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READ_ROM  = 3'd1,
        ST_WRITE_RAM = 3'd2,
        ST_READ_RAM  = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    // ROM contents: the full-width product plus offset, truncated to the data width.
    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        logic [63:0] full;
        full = 64'(a) * 64'(ROM_MUL) + 64'(ROM_ADD);
        return full[DATA_W-1:0];
    endfunction

    state_t              state_q,    state_d;
    logic [DIV_W-1:0]    div_q,      div_d;
    logic                link_clk_q, link_clk_d;
    logic [ADDR_W-1:0]   addr_q,     addr_d;
    logic [DATA_W-1:0]   data_q,     data_d;
    logic                wr_en_q,    wr_en_d;
    logic                busy_q,     busy_d;
    logic                done_q,     done_d;
    logic [1:0]          phase_q,    phase_d;
    logic [7:0]          pass_cnt_q, pass_cnt_d;

    logic                run_s;
    logic                active_s;
    logic                tick_s;
    logic                slot_end_s;
    logic                addr_wrap_s;
    logic [7:0]          pass_inc_s;
    logic                last_pass_s;

    // Qualifiers for the divider tick, slot end and end of phase.
    always_comb begin
        run_s       = (state_q == ST_READ_ROM) || (state_q == ST_WRITE_RAM) ||
                      (state_q == ST_READ_RAM);
        active_s    = run_s && en;
        tick_s      = active_s && (div_q == DIV_LAST);
        slot_end_s  = tick_s && link_clk_q;
        addr_wrap_s = slot_end_s && (addr_q == ADDR_LAST);
    end

    // Saturating pass increment, and the check for the final pass.
    always_comb begin
        pass_inc_s  = (pass_cnt_q == 8'hFF) ? 8'hFF : (pass_cnt_q + 8'd1);
        last_pass_s = (PASSES != 0) && (32'(pass_inc_s) == 32'(PASSES));
    end

    // Next-state logic: phase sequencing, divider, link clock and address walk.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        link_clk_d = link_clk_q;
        addr_d     = addr_q;
        pass_cnt_d = pass_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d    = ST_READ_ROM;
                    div_d      = '0;
                    link_clk_d = 1'b0;
                    addr_d     = '0;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_READ_ROM, ST_WRITE_RAM, ST_READ_RAM: begin
                // The divider and link clock hold completely while paused.
                if (tick_s) begin
                    div_d      = '0;
                    link_clk_d = ~link_clk_q;
                end else if (active_s) begin
                    div_d      = div_q + DIV_W'(1);
                end else begin
                    div_d      = div_q;
                end
                // The address, and at a wrap the phase, move only at a slot end.
                if (addr_wrap_s) begin
                    addr_d = '0;
                    case (state_q)
                        ST_READ_ROM:  state_d = ST_WRITE_RAM;
                        ST_WRITE_RAM: state_d = ST_READ_RAM;
                        ST_READ_RAM: begin
                            pass_cnt_d = pass_inc_s;
                            state_d    = last_pass_s ? ST_DONE : ST_READ_ROM;
                        end
                        default:      state_d = ST_IDLE;
                    endcase
                end else if (slot_end_s) begin
                    addr_d = addr_q + ADDR_W'(1);
                end else begin
                    addr_d = addr_q;
                end
            end
            ST_DONE: begin
                // DONE is terminal. Only rst leaves it, and en has no effect here.
                state_d    = ST_DONE;
                div_d      = '0;
                link_clk_d = 1'b0;
                addr_d     = '0;
            end
            default: begin
                state_d    = ST_IDLE;
                div_d      = '0;
                link_clk_d = 1'b0;
                addr_d     = '0;
            end
        endcase
    end

    // Decode the outputs from the next state so that they register in step with it.
    always_comb begin
        wr_en_d = (state_d == ST_WRITE_RAM);
        busy_d  = (state_d == ST_READ_ROM) || (state_d == ST_WRITE_RAM) ||
                  (state_d == ST_READ_RAM);
        done_d  = (state_d == ST_DONE);
        data_d  = rom_word(addr_d);
        case (state_d)
            ST_READ_ROM:  phase_d = 2'd0;
            ST_WRITE_RAM: phase_d = 2'd1;
            ST_READ_RAM:  phase_d = 2'd2;
            default:      phase_d = 2'd3;
        endcase
    end

    // State and output registers, with a synchronous reset that takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            link_clk_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= rom_word('0);
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            phase_q    <= 2'd3;
            pass_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            link_clk_q <= link_clk_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wr_en_q    <= wr_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            phase_q    <= phase_d;
            pass_cnt_q <= pass_cnt_d;
        end
    end

    assign link_clk = link_clk_q;
    assign wr_en    = wr_en_q;
    assign o_addr   = addr_q;
    assign o_data   = data_q;
    assign leds     = data_q;
    assign phase    = phase_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass_cnt = pass_cnt_q;

endmodule

// File: doc/rom_link_tx.md
Name: rom_link_tx

Overview:
- Parametrised transmit side of the board-to-board ROM→RAM link.
- Walks every address of a generated ROM and drives address, data, write-enable and a slow link clock to the peer FPGA.
- Runs a fixed phase sequence READ_ROM → WRITE_RAM → READ_RAM for a programmable number of passes.
- Adds over the first-generation link: enable/pause, a configurable divider, a pass limit, a done flag and phase/status outputs.

Parameters:
- DATA_W, 4: data width.
- ADDR_W, 4: address width; DEPTH = 2**ADDR_W.
- CLK_DIV, 50_000_000: clk cycles per link_clk half-period; must be ≥ 1.
- ROM_MUL, 1: ROM content multiplier.
- ROM_ADD, 0: ROM content offset.
- PASSES, 0: number of full passes before DONE; 0 = run forever.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  synchronous reset, active-high.
- en  in  1  run enable; low = pause.
- link_clk  out  1  slow clock to peer; 50% duty.
- wr_en  out  1  peer RAM write enable.
- o_addr  out  ADDR_W  address to peer.
- o_data  out  DATA_W  ROM data to peer.
- leds  out  DATA_W  copy of o_data.
- phase  out  2  0 = READ_ROM, 1 = WRITE_RAM, 2 = READ_RAM, 3 = idle/done.
- busy  out  1  high in READ_ROM, WRITE_RAM and READ_RAM.
- done  out  1  high in DONE.
- pass_cnt  out  8  completed passes, saturating at 255.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state = IDLE, divider = 0, link_clk = 0, o_addr = 0, o_data = rom(0), wr_en = 0, busy = 0, done = 0, pass_cnt = 0, phase = 3.
  - Reset overrides everything in every state, including mid-pass.
- ROM function: rom(a) = (a*ROM_MUL + ROM_ADD) mod 2**DATA_W.
  - Full-width product, then truncated.
  - Defaults give rom(a) = a.
- o_data is registered and updates in the same cycle as o_addr, so o_data == rom(o_addr) on every cycle with zero skew. leds == o_data.
- Divider (width clog2(CLK_DIV), minimum 1 bit):
  - Counts 0..CLK_DIV-1 only while busy=1 and en=1.
  - On the terminal count it wraps to 0 and produces a one-cycle internal tick.
  - Each tick toggles link_clk.
  - A tick that drives link_clk 1→0 is a slot end. One slot = 2*CLK_DIV clk cycles.
- Pause: with en=0 the divider, link_clk, o_addr, state and wr_en all hold their values. Setting en=1 resumes from exactly the held point.
- FSM:
  - IDLE: on en=1, go to READ_ROM on the next edge; divider = 0, o_addr = 0.
  - At each slot end, o_addr increments. The peer samples on link_clk rising, mid-slot.
  - At the slot end with o_addr == DEPTH-1, o_addr wraps to 0 and the phase advances:
    - READ_ROM → WRITE_RAM.
    - WRITE_RAM → READ_RAM.
    - READ_RAM → pass_cnt+1; go to DONE if PASSES≠0 and the new pass_cnt == PASSES, otherwise READ_ROM.
  - DONE: link_clk = 0, o_addr = 0, wr_en = 0, busy = 0, done = 1. Exit only through rst; en is ignored.
- wr_en = 1 exactly while state == WRITE_RAM. It changes only at a slot end, never mid-slot.
- Timing per pass: one phase = DEPTH slots; one pass = 3*DEPTH slots = 6*DEPTH*CLK_DIV clk cycles, excluding pauses.
- CLK_DIV = 1: tick every enabled cycle; link_clk toggles every cycle.
- Wrap and phase change are a single-edge event: o_addr = 0 and the new phase/wr_en appear together.
- pass_cnt saturates at 255 and does not wrap; with PASSES = 0 the FSM keeps looping.

Test Plan:
- Defaults except CLK_DIV=2, ADDR_W=2, PASSES=1; rst then en=1 held → link_clk period is 4 clk; o_addr runs 0,1,2,3 three times; wr_en=1 only during slots 4–7; done=1 and pass_cnt=1 after 48 clk from READ_ROM entry; link_clk then stays 0.
- ROM_MUL=3, ROM_ADD=5, DATA_W=4 → o_data sequence 5,8,11,14,1,4,… (mod 16); o_data == rom(o_addr) checked on every cycle.
- Drop en for 10 cycles mid-WRITE_RAM at o_addr=2 → o_addr, wr_en=1, link_clk and phase=1 frozen; after en returns, the remaining slot time completes unchanged and total cycles = 48 + 10.
- Assert rst for one cycle while in READ_RAM at o_addr=3 → next cycle all outputs at reset values; phase=3, busy=0.
- CLK_DIV=1, ADDR_W=1, PASSES=0, run 100 cycles → link_clk toggles every cycle; phase cycles 0,1,2 every 4 cycles; done never asserts; pass_cnt increments every 12 cycles.
- PASSES=0, run more than 255 passes → pass_cnt holds at 255 and busy stays 1.
